// File: rtl/clkgen_multi.sv
// Multi-channel synchronous clock divider with per-channel phase lag,
// one-cycle enable strobes, a settle-time lock flag and a valid/ready reconfig port.
module clkgen_multi #(
  parameter int NUM_CLOCKS = 2,
  parameter int DIV_W = 8,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DEFAULT_DIV = {8'd4, 8'd4},
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DEFAULT_PHASE = {8'd2, 8'd0},
  localparam int SEL_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic                  locked
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN_WAIT   = 2'd0,
    RUN_LOCKED = 2'd1,
    RESYNC     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_wr;
  logic             cfg_wr_legal;
  logic             sel_legal;
  logic             clamp_hit;
  logic [DIV_W-1:0] div_clamp;
  logic [DIV_W-1:0] ph_clamp;

  assign cfg_wr       = cfg_valid && cfg_ready_q;
  assign sel_legal    = (32'(cfg_sel) < NUM_CLOCKS);
  assign cfg_wr_legal = cfg_wr && sel_legal;

  // Ratios below 2 cannot toggle; a phase lag must stay inside one period.
  assign div_clamp = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign ph_clamp  = (cfg_phase < div_clamp) ? cfg_phase : '0;
  assign clamp_hit = (cfg_div < DIV_W'(2)) || (cfg_phase >= div_clamp);

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    cfg_ready_d = 1'b1;
    cfg_err_d   = 1'b0;
    case (state_q)
      RUN_WAIT, RUN_LOCKED: begin
        if (cfg_wr_legal) begin
          state_d     = RESYNC;
          locked_d    = 1'b0;
          cfg_ready_d = 1'b0;
          cfg_err_d   = clamp_hit;
        end else begin
          cfg_err_d = cfg_wr;
          if (state_q == RUN_WAIT) begin
            lock_cnt_d = lock_cnt_q + LCK_W'(1);
            if (lock_cnt_d == LCK_W'(LOCK_CYCLES)) begin
              state_d  = RUN_LOCKED;
              locked_d = 1'b1;
            end
          end
        end
      end
      RESYNC: begin
        state_d    = RUN_WAIT;
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
      default: begin
        state_d     = RESYNC;
        cfg_ready_d = 1'b0;
        locked_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= RUN_WAIT;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign locked    = locked_q;

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
    localparam logic [DIV_W-1:0] DEF_DIV = DEFAULT_DIV[gi*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] DEF_PH  = DEFAULT_PHASE[gi*DIV_W +: DIV_W];

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] ph_q, ph_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             outclk_q, outclk_d;
    logic             clk_en_q, clk_en_d;
    logic             wr_ch;

    assign wr_ch = cfg_wr_legal && (32'(cfg_sel) == gi);

    // Loading div-1-ph makes the first running edge land on (div-ph) mod div.
    always_comb begin
      div_d    = div_q;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      outclk_d = 1'b0;
      clk_en_d = 1'b0;
      if (state_q == RESYNC) begin
        cnt_d = div_q - DIV_W'(1) - ph_q;
      end else if (cfg_wr_legal) begin
        if (wr_ch) begin
          div_d = div_clamp;
          ph_d  = ph_clamp;
        end
      end else begin
        cnt_d    = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        outclk_d = (cnt_d < (div_q >> 1));
        clk_en_d = (cnt_d == div_q - DIV_W'(1));
      end
    end

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        div_q    <= DEF_DIV;
        ph_q     <= DEF_PH;
        cnt_q    <= DEF_DIV - DIV_W'(1) - DEF_PH;
        outclk_q <= 1'b0;
        clk_en_q <= 1'b0;
      end else begin
        div_q    <= div_d;
        ph_q     <= ph_d;
        cnt_q    <= cnt_d;
        outclk_q <= outclk_d;
        clk_en_q <= clk_en_d;
      end
    end

    assign outclk[gi] = outclk_q;
    assign clk_en[gi] = clk_en_q;
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi (3 channels): hand-derived vector table, directed corner
// sequences and a random run against a period/phase arithmetic reference model.
module tb_clkgen_multi;
  localparam int NC = 3;
  localparam int LC = 16;
  localparam int DEF_DIV[NC] = '{4, 4, 5};
  localparam int DEF_PH[NC]  = '{0, 2, 1};

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_phase = '0;
  logic       cfg_ready, cfg_err, locked;
  logic [2:0] outclk, clk_en;

  int vectors = 0;
  int miscompares = 0;

  clkgen_multi #(
    .NUM_CLOCKS   (NC),
    .DIV_W        (8),
    .LOCK_CYCLES  (LC),
    .DEFAULT_DIV  ({8'd5, 8'd4, 8'd4}),
    .DEFAULT_PHASE({8'd1, 8'd2, 8'd0})
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .clk_en   (clk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: channel count = (div - ph + n) mod div, n = running edges since restart.
  int         m_div[NC];
  int         m_ph[NC];
  int         run_n = 0;
  bit         m_resync = 0, m_ready = 0, m_locked = 0, m_err = 0;
  logic [2:0] m_out = '0, m_en = '0;

  task automatic model_edge();
    bit acc;
    int d, p, c;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_div[i] = DEF_DIV[i];
        m_ph[i]  = DEF_PH[i];
      end
      run_n = 0; m_resync = 0; m_ready = 0; m_locked = 0; m_err = 0;
      m_out = '0; m_en = '0;
    end else if (m_resync) begin
      run_n = 0; m_resync = 0; m_ready = 1; m_locked = 0; m_err = 0;
      m_out = '0; m_en = '0;
    end else begin
      acc = cfg_valid && m_ready;
      if (acc && int'(cfg_sel) < NC) begin
        d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        p = (int'(cfg_phase) < d) ? int'(cfg_phase) : 0;
        m_err = (d != int'(cfg_div)) || (p != int'(cfg_phase));
        m_div[cfg_sel] = d;
        m_ph[cfg_sel]  = p;
        m_resync = 1; m_ready = 0; m_locked = 0;
        m_out = '0; m_en = '0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          c = (m_div[i] - m_ph[i] + run_n) % m_div[i];
          m_out[i] = (c < m_div[i] / 2);
          m_en[i]  = (c == m_div[i] - 1);
        end
        run_n++;
        m_locked = (run_n >= LC);
        m_ready = 1;
        m_err = acc;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    @(negedge refclk);
    chk("model_outclk", 32'(outclk), 32'(m_out));
    chk("model_clk_en", 32'(clk_en), 32'(m_en));
    chk("model_locked", 32'(locked), 32'(m_locked));
    chk("model_cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic wait_locked();
    int n = 0;
    while (!locked && n < 40) begin
      step();
      n++;
    end
    chk("wait_locked", 32'(locked), 32'd1);
  endtask

  typedef struct {
    logic       rst_n;
    logic [2:0] outclk;
    logic [2:0] clk_en;
    logic       locked;
    logic       ready;
  } vec_t;

  vec_t tbl[10];

  task automatic apply_table(input int first);
    for (int v = first; v < 10; v++) begin
      rst_n = tbl[v].rst_n;
      step();
      chk($sformatf("tbl%0d_outclk", v), 32'(outclk), 32'(tbl[v].outclk));
      chk($sformatf("tbl%0d_clk_en", v), 32'(clk_en), 32'(tbl[v].clk_en));
      chk($sformatf("tbl%0d_locked", v), 32'(locked), 32'(tbl[v].locked));
      chk($sformatf("tbl%0d_ready", v), 32'(cfg_ready), 32'(tbl[v].ready));
    end
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [7:0] dv, input logic [7:0] ph);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_div = dv; cfg_phase = ph;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int exp_ch0[7];
    int exp_ch1[7];
    int d;
    exp_ch0 = '{1, 1, 0, 0, 1, 1, 0};
    exp_ch1 = '{0, 1, 1, 1, 0, 0, 0};
    // {rst_n, outclk{2,1,0}, clk_en{2,1,0}, locked, ready}
    tbl[0] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'b001, 3'b100, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'b101, 3'b010, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 3'b110, 3'b000, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 3'b010, 3'b001, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 3'b001, 3'b000, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 3'b001, 3'b110, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 3'b110, 3'b000, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 3'b110, 3'b001, 1'b0, 1'b1};

    apply_table(0);

    // Lock timing: edges 9..16 after release.
    for (int k = 9; k <= 16; k++) begin
      step();
      chk($sformatf("lock_edge%0d", k), 32'(locked), (k >= LC) ? 32'd1 : 32'd0);
    end

    // One-cycle reset while locked, then the release sequence must repeat.
    rst_n = 1'b0;
    step();
    chk("rst_pulse_outclk", 32'(outclk), 32'd0);
    chk("rst_pulse_locked", 32'(locked), 32'd0);
    apply_table(2);
    wait_locked();

    // Reconfigure ch1 to div 6 phase 1 while locked.
    write_cfg(2'd1, 8'd6, 8'd1);
    chk("recfg_E_ready", 32'(cfg_ready), 32'd0);
    chk("recfg_E_outclk", 32'(outclk), 32'd0);
    chk("recfg_E_err", 32'(cfg_err), 32'd0);
    step();
    chk("recfg_E1_outclk", 32'(outclk), 32'd0);
    chk("recfg_E1_clk_en", 32'(clk_en), 32'd0);
    for (int k = 1; k <= LC; k++) begin
      step();
      if (k <= 7) begin
        chk($sformatf("recfg_ch1_k%0d", k), 32'(outclk[1]), 32'(exp_ch1[k-1]));
        chk($sformatf("recfg_ch0_k%0d", k), 32'(outclk[0]), 32'(exp_ch0[k-1]));
      end
      chk($sformatf("recfg_lock_k%0d", k), 32'(locked), (k == LC) ? 32'd1 : 32'd0);
    end

    // Clamp: div 1 phase 5 -> div 2 phase 0.
    write_cfg(2'd0, 8'd1, 8'd5);
    chk("clamp1_err", 32'(cfg_err), 32'd1);
    step();
    chk("clamp1_err_drop", 32'(cfg_err), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("clamp1_toggle%0d", k), 32'(outclk[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    write_cfg(2'd0, 8'd4, 8'd4);
    chk("clamp2_err", 32'(cfg_err), 32'd1);
    step();
    chk("clamp2_err_drop", 32'(cfg_err), 32'd0);
    wait_locked();

    // Illegal select: error pulse only.
    write_cfg(2'd3, 8'd7, 8'd2);
    chk("illegal_err", 32'(cfg_err), 32'd1);
    chk("illegal_locked", 32'(locked), 32'd1);
    chk("illegal_ready", 32'(cfg_ready), 32'd1);
    step();
    chk("illegal_err_drop", 32'(cfg_err), 32'd0);
    chk("illegal_locked2", 32'(locked), 32'd1);

    // Reset landing on the RESYNC cycle restores defaults.
    write_cfg(2'd2, 8'd9, 8'd3);
    rst_n = 1'b0;
    step();
    chk("rst_resync_outclk", 32'(outclk), 32'd0);
    chk("rst_resync_ready", 32'(cfg_ready), 32'd0);
    apply_table(2);

    // Back-to-back writes with cfg_valid held high.
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd4; cfg_phase = 8'd1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b2b_ready%0d", k), 32'(cfg_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    cfg_valid = 1'b0;

    // Random run against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 6);
        1: d = 255;
        default: d = $urandom_range(0, 255);
      endcase
      cfg_div   = 8'(d);
      cfg_phase = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, d + 1));
      step();
    end
    cfg_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clkgen_multi.md
Name: clkgen_multi

Overview:
- Parametrised, fully synchronous multi-channel clock generator.
- Derives NUM_CLOCKS divided clocks from refclk, each with its own ratio and phase offset; each channel also provides a one-cycle clock-enable strobe.
- Asserts locked after a programmable settle time.
- Runtime-reconfigurable through a valid/ready config port. Lives in the clocking subsystem next to the SDRAM/system PLL and feeds slow peripherals and enable-based logic.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16).
- DIV_W, 8, width of the divide and phase fields.
- LOCK_CYCLES, 16, refclk cycles from resync to locked (>=1).
- DEFAULT_DIV, {8'd4,8'd4}, packed per-channel reset divide ratios, channel 0 in the LSBs.
- DEFAULT_PHASE, {8'd2,8'd0}, packed per-channel reset phase lags in refclk cycles, channel 0 in the LSBs.
- SEL_W (localparam), max(1,clog2(NUM_CLOCKS)), width of cfg_sel.

Ports:
- refclk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write may be accepted.
- cfg_sel  in  SEL_W  target channel.
- cfg_div  in  DIV_W  new divide ratio.
- cfg_phase  in  DIV_W  new phase lag.
- cfg_err  out  1  one-cycle pulse: accepted write was illegal or clamped.
- outclk  out  NUM_CLOCKS  divided clocks, registered.
- clk_en  out  NUM_CLOCKS  one-cycle enable per channel period, registered.
- locked  out  1  all channels running and settled.

Behaviour:
- Per-channel state: div[i], ph[i], cnt[i] (all DIV_W bits). Shared state: FSM {RUN_WAIT, RUN_LOCKED, RESYNC} and lock_cnt.
- Reset (rst_n=0 at an edge):
  - div/ph load DEFAULT_*; cnt[i] <= div[i]-1-ph[i]; state RUN_WAIT; lock_cnt 0.
  - outclk=0, clk_en=0, locked=0, cfg_ready=0, cfg_err=0.
  - cfg_valid is ignored.
  - Reset applies identically mid-operation, including during RESYNC.
- Running (RUN_WAIT or RUN_LOCKED):
  - Each edge: cnt[i] <= (cnt[i]==div[i]-1) ? 0 : cnt[i]+1.
  - outclk[i] <= (new cnt[i] < div[i]>>1).
  - clk_en[i] <= (new cnt[i] == div[i]-1).
  - Result: first cycle after reset release/resync has cnt = (div-ph) mod div, so a channel lags phase 0 by ph cycles. Odd ratios give high time floor(div/2).
- Lock:
  - In RUN_WAIT, lock_cnt increments each edge. On the edge where it reaches LOCK_CYCLES, state becomes RUN_LOCKED and locked=1.
  - locked rises on the LOCK_CYCLES-th edge after reset release or after RESYNC, and stays 1 until reset or an accepted legal write.
- cfg_ready = 1 in RUN_WAIT and RUN_LOCKED; 0 in RESYNC and during reset. A write is accepted on an edge with cfg_valid & cfg_ready.
- Accepted write, legal cfg_sel (< NUM_CLOCKS):
  - div[sel] <= max(cfg_div, 2).
  - ph[sel] <= (cfg_phase < clamped div) ? cfg_phase : 0.
  - cfg_err=1 for one cycle if either value was clamped.
  - state <= RESYNC; locked <= 0; outclk, clk_en <= 0.
- Accepted write, illegal cfg_sel: no state change, no resync, locked unchanged, cfg_err pulses for one cycle.
- RESYNC (exactly one cycle):
  - All channels reload cnt[i] <= div[i]-1-ph[i], keeping their mutual phase alignment.
  - lock_cnt <= 0; outputs held 0; next state RUN_WAIT.
- Divide range: cnt never exceeds div-1 and wraps to 0. div = 2^DIV_W-1 is legal. No arithmetic overflow is permitted in the compare.
- Outputs are flop-driven only; there is no combinational path from inputs to outputs.

Test Plan:
1. Defaults, release reset at edge 0: outclk[0]=1,1,0,0 repeating and clk_en[0] high on cycles 4,8,…; outclk[1]=0,0,1,1 and clk_en[1] high on cycles 2,6,….
2. Lock timing: locked=0 through edge 15 after release and 1 from edge 16. Pulse rst_n=0 for one cycle while locked: all outputs 0, then the sequence from scenario 1 repeats exactly.
3. Reconfig while locked, write sel=1 div=6 phase=1 at edge E:
   - cfg_ready=0 and outputs 0 at E+1.
   - From E+2, ch1 cnt runs 5,0,1,…; outclk[1] follows that count (low on cnt 5, high on cnt 0..2); ch0 restarts phase 0.
   - locked rises at edge E+1+16.
4. Clamping: write div=1 phase=5 -> div 2, phase 0, cfg_err one-cycle pulse, ch toggles every cycle. Write div=4 phase=4 -> phase 0, cfg_err pulses.
5. Illegal select with NUM_CLOCKS=3, write sel=3: cfg_err pulses; locked, cfg_ready and all channel waveforms are unchanged.
6. Reset during RESYNC cycle: default state is restored. Back-to-back cfg_valid held high: second write is accepted only after RESYNC (cfg_ready gap of exactly 1 cycle).
